fifo_pkt_sync: RTL and testbench

- Packet-aware synchronous FIFO, successor to the filter's word FIFO; sits between the packet filter datapath and the egress side.
- Write side builds each packet speculatively. Read side sees only committed (complete, error-free) packets.
- Packets are discarded on explicit drop or on overflow, with no external pointer juggling.
- Read port is first-word-fall-through with per-word last flag, committed-packet count, fill level and almost-full.

---
 rtl/fifo_pkt_sync.sv | 139 +++++++++++++
 tb/tb_fifo_pkt_sync.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_sync.sv
// Packet-aware FWFT FIFO: the write side builds packets speculatively and commits on an
// error-free wlast; the read side prefetches committed words only, through RAM and head registers.
module fifo_pkt_sync #(
  parameter int ADDR_WIDTH   = 11,
  parameter int W_EL         = 20,
  parameter int AFULL_MARGIN = 16,
  parameter int W_DROPCNT    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [W_EL-1:0]       wdata,
  input  logic                  wlast,
  input  logic                  wen,
  input  logic                  wdrop,
  output logic                  full,
  output logic                  afull,
  output logic [W_EL-1:0]       rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  ren,
  output logic [ADDR_WIDTH:0]   pkt_count,
  output logic [ADDR_WIDTH:0]   level,
  output logic [W_DROPCNT-1:0]  drop_count
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] MARGIN_P = PW'(AFULL_MARGIN);
  localparam logic [W_DROPCNT-1:0] DROP_MAX = '1;

  logic [W_EL:0] mem [DEPTH];
  logic [W_EL:0] ram_q;
  logic [W_EL:0] head_q;
  logic          ram_v_q, head_v_q;
  logic [PW-1:0] wptr_spec_q, wptr_spec_d;
  logic [PW-1:0] wptr_commit_q, wptr_commit_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] fptr_q;
  logic [PW-1:0] used_d, free_d;
  logic          err_q, err_d;
  logic [PW-1:0] pkt_count_q, pkt_count_d;
  logic [W_DROPCNT-1:0] drop_q, drop_d;
  logic          full_q, afull_q;
  logic          store, commit, drop_pkt;
  logic          pop, fetch, ram_to_head;

  // Write side; an overflowing word that is also the last one ends its packet as a drop.
  always_comb begin
    wptr_spec_d   = wptr_spec_q;
    wptr_commit_d = wptr_commit_q;
    err_d         = err_q;
    store         = 1'b0;
    commit        = 1'b0;
    drop_pkt      = 1'b0;
    if (wdrop) begin
      drop_pkt = 1'b1;
    end else if (wen) begin
      if (err_q) begin
        drop_pkt = wlast;
      end else if (full_q) begin
        if (wlast) drop_pkt = 1'b1;
        else       err_d    = 1'b1;
      end else begin
        store       = 1'b1;
        wptr_spec_d = wptr_spec_q + 1'b1;
        if (wlast) begin
          commit        = 1'b1;
          wptr_commit_d = wptr_spec_q + 1'b1;
        end
      end
    end
    if (drop_pkt) begin
      wptr_spec_d = wptr_commit_q;
      err_d       = 1'b0;
    end
  end

  assign drop_d = (drop_pkt && drop_q != DROP_MAX) ? drop_q + 1'b1 : drop_q;

  // Two-entry prefetch (RAM output register, then head) sustains one pop per cycle.
  assign pop         = ren & head_v_q;
  assign ram_to_head = ram_v_q & (~head_v_q | pop);
  assign fetch       = (fptr_q != wptr_commit_q) & (~ram_v_q | ram_to_head);
  assign rptr_d      = rptr_q + PW'(pop);
  assign pkt_count_d = pkt_count_q + PW'(commit) - PW'(pop & head_q[W_EL]);
  assign used_d      = wptr_spec_d - rptr_d;
  assign free_d      = DEPTH_P - used_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_spec_q   <= '0;
      wptr_commit_q <= '0;
      rptr_q        <= '0;
      fptr_q        <= '0;
      err_q         <= 1'b0;
      pkt_count_q   <= '0;
      drop_q        <= '0;
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
      ram_v_q       <= 1'b0;
      head_v_q      <= 1'b0;
      head_q        <= '0;
    end else begin
      wptr_spec_q   <= wptr_spec_d;
      wptr_commit_q <= wptr_commit_d;
      rptr_q        <= rptr_d;
      fptr_q        <= fptr_q + PW'(fetch);
      err_q         <= err_d;
      pkt_count_q   <= pkt_count_d;
      drop_q        <= drop_d;
      full_q        <= (used_d == DEPTH_P);
      afull_q       <= (free_d <= MARGIN_P);
      if (fetch)            ram_v_q <= 1'b1;
      else if (ram_to_head) ram_v_q <= 1'b0;
      if (ram_to_head) begin
        head_q   <= ram_q;
        head_v_q <= 1'b1;
      end else if (pop) begin
        head_v_q <= 1'b0;
      end
    end
  end

  // Storage without reset so it maps onto block RAM; ram_q is qualified by ram_v_q.
  always_ff @(posedge clk) begin
    if (store) mem[wptr_spec_q[ADDR_WIDTH-1:0]] <= {wlast, wdata};
    if (fetch) ram_q <= mem[fptr_q[ADDR_WIDTH-1:0]];
  end

  assign full       = full_q;
  assign afull      = afull_q;
  assign rvalid     = head_v_q;
  assign rdata      = head_q[W_EL-1:0];
  assign rlast      = head_v_q & head_q[W_EL];
  assign pkt_count  = pkt_count_q;
  assign level      = wptr_commit_q - rptr_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fifo_pkt_sync.sv
// Bench for fifo_pkt_sync: queue-based packet model checked every cycle, plus directed scenarios.
module tb_fifo_pkt_sync;
  localparam int AW = 4;
  localparam int W = 20;
  localparam int MARGIN = 4;
  localparam int WD = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [W-1:0] wdata = '0;
  logic wlast = 1'b0, wen = 1'b0, wdrop = 1'b0, ren = 1'b0;
  logic full, afull, rlast, rvalid;
  logic [W-1:0] rdata;
  logic [AW:0] pkt_count, level;
  logic [WD-1:0] drop_count;

  always #5 clk = ~clk;

  fifo_pkt_sync #(.ADDR_WIDTH(AW), .W_EL(W), .AFULL_MARGIN(MARGIN), .W_DROPCNT(WD)) dut (
    .clk(clk), .reset_n(reset_n), .wdata(wdata), .wlast(wlast), .wen(wen), .wdrop(wdrop),
    .full(full), .afull(afull), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .ren(ren),
    .pkt_count(pkt_count), .level(level), .drop_count(drop_count)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Model: committed words awaiting pop, words of the packet being built, overflow flag.
  logic [W:0] cq[$];
  logic [W:0] sq[$];
  bit merr;
  int mpkt, mdrop, nr, n_pop, n_pop_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bump_drop();
    if (mdrop < 2 ** WD - 1) mdrop++;
  endtask

  always @(negedge clk) begin
    int occ;
    bit pop;
    if (!reset_n) begin
      cq.delete(); sq.delete();
      merr = 0; mpkt = 0; mdrop = 0; nr = 0; n_pop = 0; n_pop_last = 0;
    end else begin
      occ = cq.size() + sq.size();
      chk("level", level, cq.size());
      chk("pkt_count", pkt_count, mpkt);
      chk("drop_count", drop_count, mdrop);
      chk("full", full, occ == DEPTH);
      chk("afull", afull, (DEPTH - occ) <= MARGIN);
      if (rvalid) begin
        if (cq.size() == 0) chk("rvalid_spurious", rvalid, 0);
        else chk("head_word", {rlast, rdata}, cq[0]);
      end else begin
        chk("rlast_idle", rlast, 0);
      end
      if (cq.size() > 0 && nr >= 2) chk("rvalid_latency", rvalid, 1);
      nr = (cq.size() > 0 && !rvalid) ? nr + 1 : 0;

      pop = ren && rvalid;
      if (wdrop) begin
        sq.delete(); merr = 0; bump_drop();
      end else if (wen) begin
        if (merr) begin
          if (wlast) begin sq.delete(); merr = 0; bump_drop(); end
        end else if (occ == DEPTH) begin
          if (wlast) begin sq.delete(); bump_drop(); end
          else merr = 1;
        end else begin
          sq.push_back({wlast, wdata});
          if (wlast) begin
            foreach (sq[k]) cq.push_back(sq[k]);
            sq.delete();
            mpkt++;
          end
        end
      end
      if (pop && cq.size() > 0) begin
        n_pop++;
        if (cq[0][W]) begin mpkt--; n_pop_last++; end
        void'(cq.pop_front());
      end
    end
  end

  task automatic step(input bit e, input logic [W-1:0] d, input bit l, input bit dr, input bit r);
    wen = e; wdata = d; wlast = l; wdrop = dr; ren = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    wen = 0; wlast = 0; wdrop = 0; ren = 0; wdata = '0;
    #2 reset_n = 0;
    #1;
    chk("rst_rvalid", rvalid, 0); chk("rst_rlast", rlast, 0); chk("rst_rdata", rdata, 0);
    chk("rst_full", full, 0); chk("rst_afull", afull, 0); chk("rst_level", level, 0);
    chk("rst_pkt", pkt_count, 0); chk("rst_drop", drop_count, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
  endtask

  initial begin
    bit saw_full;
    int wcnt;
    bit e;

    // Basic 3-word packet, read latency and ordering.
    do_reset();
    step(1, 'hA, 0, 0, 1); step(1, 'hB, 0, 0, 1); step(1, 'hC, 1, 0, 1);
    chk("t1_rvalid_n0", rvalid, 0); chk("t1_pkt", pkt_count, 1); chk("t1_level", level, 3);
    step(0, 0, 0, 0, 1); chk("t1_rvalid_n1", rvalid, 0);
    step(0, 0, 0, 0, 1); chk("t1_rvalid_n2", rvalid, 1); chk("t1_a", rdata, 'hA); chk("t1_a_last", rlast, 0);
    step(0, 0, 0, 0, 1); chk("t1_b", rdata, 'hB); chk("t1_b_last", rlast, 0);
    step(0, 0, 0, 0, 1); chk("t1_c", rdata, 'hC); chk("t1_c_last", rlast, 1); chk("t1_level_c", level, 1);
    step(0, 0, 0, 0, 1); chk("t1_empty", rvalid, 0); chk("t1_pkt0", pkt_count, 0); chk("t1_level0", level, 0);

    // Explicit drop of a partial packet, then a 1-word packet.
    step(1, 'h11, 0, 0, 1); step(1, 'h12, 0, 0, 1); step(0, 0, 0, 1, 1);
    step(1, 'hD, 1, 0, 1);
    chk("t2_level", level, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    chk("t2_d", rdata, 'hD);
    repeat (2) step(0, 0, 0, 0, 1);
    chk("t2_drop", drop_count, 1); chk("t2_level0", level, 0);

    // Oversized packet with no reads overflows and is dropped.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, W'('h100 + i), i == 19, 0, 0);
      if (i == 10) chk("t3_afull_lo", afull, 0);
      if (i == 11) chk("t3_afull_hi", afull, 1);
      if (i == 15) chk("t3_full", full, 1);
    end
    chk("t3_drop", drop_count, 1); chk("t3_level", level, 0); chk("t3_full_clr", full, 0);
    for (int i = 0; i < 4; i++) step(1, W'('h300 + i), i == 3, 0, 0);
    chk("t3_pkt", pkt_count, 1); chk("t3_level4", level, 4);
    repeat (8) step(0, 0, 0, 0, 1);
    chk("t3_drained", level, 0);

    // Commit of P2 on the same edge as P1's last pop.
    do_reset();
    step(1, 'h201, 0, 0, 1); step(1, 'h202, 1, 0, 1);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    step(1, 'h203, 0, 0, 1); chk("t4_pkt_pre", pkt_count, 1);
    step(1, 'h204, 1, 0, 1); chk("t4_pkt_same", pkt_count, 1); chk("t4_level", level, 2);
    repeat (6) step(0, 0, 0, 0, 1);
    chk("t4_pkt0", pkt_count, 0);

    // Streaming 100 four-word packets across pointer wrap.
    do_reset();
    saw_full = 0; wcnt = 0;
    while (wcnt < 400) begin
      e = 1'($urandom_range(0, 1));
      step(e, W'(wcnt), e && (wcnt % 4 == 3), 0, e ? 1'b1 : 1'($urandom_range(0, 1)));
      if (e) wcnt++;
      saw_full |= full;
    end
    repeat (10) step(0, 0, 0, 0, 1);
    chk("t5_words", n_pop, 400); chk("t5_lasts", n_pop_last, 100); chk("t5_never_full", saw_full, 0);

    // Random mix of packet lengths, drops, overflows and read gaps.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 1000; c++) begin
        step($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 4 + 6 * ph) == 0,
             $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3 + 3 * ph);
      end
    end
    repeat (10) step(0, 0, 0, 0, 1);

    // Drop counter saturation.
    do_reset();
    repeat (20) step(0, 0, 0, 1, 0);
    chk("t7_drop_sat", drop_count, 15);

    // Asynchronous reset mid-packet and mid-read.
    do_reset();
    step(0, 0, 0, 1, 0);
    step(1, 'h51, 0, 0, 0); step(1, 'h52, 0, 0, 0); step(1, 'h53, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 'h54, 0, 0, 1);
    chk("t8_pre_rvalid", rvalid, 1);
    #3 reset_n = 0;
    #1;
    chk("t8_rvalid", rvalid, 0); chk("t8_rdata", rdata, 0); chk("t8_rlast", rlast, 0);
    chk("t8_level", level, 0); chk("t8_pkt", pkt_count, 0); chk("t8_drop", drop_count, 0);
    chk("t8_full", full, 0); chk("t8_afull", afull, 0);
    wen = 0; wdrop = 0; ren = 0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1;
    step(1, 'h3AB, 1, 0, 1);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    chk("t8_rt_valid", rvalid, 1); chk("t8_rt_data", rdata, 'h3AB); chk("t8_rt_last", rlast, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    chk("t8_rt_level", level, 0); chk("t8_rt_drop", drop_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
